// File: rtl/sm_iter_divider_if.sv
// Start/busy/done request and result bundle for sm_iter_divider.
// master drives operands and start; slave returns the result.
interface sm_iter_divider_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic             dividend_sign;
    logic [WIDTH-1:0] divisor;
    logic             divisor_sign;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic             quotient_sign;
    logic [WIDTH-1:0] remainder;
    logic             remainder_sign;
    logic             div_by_zero;

    modport master (
        output start, dividend, dividend_sign, divisor, divisor_sign,
        input  busy, done, quotient, quotient_sign,
        input  remainder, remainder_sign, div_by_zero
    );

    modport slave (
        input  start, dividend, dividend_sign, divisor, divisor_sign,
        output busy, done, quotient, quotient_sign,
        output remainder, remainder_sign, div_by_zero
    );
endinterface

// File: rtl/sm_iter_divider.sv
// Sequential restoring sign-magnitude divider, one quotient bit per cycle.
// Optional SM_DIV_FAST_ZERO_EN: zero dividend completes in one cycle.
module sm_iter_divider #(
    parameter int WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_iter_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_dd_sign;
    logic             r_dv_sign;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_qs;
    logic             r_rs;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_ge;
    logic             w_last;
    logic             w_dvs_zero;
    logic             w_acc;
    logic             w_ld_dbz;
    logic             w_ld_zero;
    logic             w_ld_run;

    // r_quo doubles as the dividend shifter: its MSB feeds the remainder.
    assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_ge       = r_rem[WIDTH] | (w_shift >= {1'b0, r_dvs});
    assign w_rem_nxt  = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
    assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
    assign w_last     = (r_cnt == CW'(1));
    assign w_dvs_zero = (bus.divisor == '0);

`ifdef SM_DIV_FAST_ZERO_EN
    logic w_dd_zero;
    assign w_dd_zero = (bus.dividend == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        w_ld_dbz    = 1'b0;
        w_ld_zero   = 1'b0;
        w_ld_run    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_acc = 1'b1;
                    if (w_dvs_zero) begin
                        w_ld_dbz    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
`ifdef SM_DIV_FAST_ZERO_EN
                    else if (w_dd_zero) begin
                        w_ld_zero   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
`endif
                    else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_ld_run    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_dd_sign <= 1'b0;
            r_dv_sign <= 1'b0;
            r_q       <= '0;
            r_qs      <= 1'b0;
            r_r       <= '0;
            r_rs      <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            if (w_acc) begin
                r_rem     <= '0;
                r_quo     <= bus.dividend;
                r_dvs     <= bus.divisor;
                r_dd_sign <= bus.dividend_sign;
                r_dv_sign <= bus.divisor_sign;
                r_cnt     <= CW'(WIDTH);
            end else if (r_state == S_RUN) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_ld_dbz) begin
                r_q   <= '1;
                r_qs  <= 1'b1;
                r_r   <= '1;
                r_rs  <= 1'b1;
                r_dbz <= 1'b1;
            end else if (w_ld_zero) begin
                r_q   <= '0;
                r_qs  <= 1'b0;
                r_r   <= '0;
                r_rs  <= 1'b0;
                r_dbz <= 1'b0;
            end else if (w_ld_run) begin
                // Zero magnitudes never carry a negative sign.
                r_q   <= w_quo_nxt;
                r_qs  <= (|w_quo_nxt) & (r_dd_sign ^ r_dv_sign);
                r_r   <= w_rem_nxt[WIDTH-1:0];
                r_rs  <= (|w_rem_nxt[WIDTH-1:0]) & r_dd_sign;
                r_dbz <= 1'b0;
            end
        end
    end

    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = (r_state == S_DONE);
    assign bus.quotient       = r_q;
    assign bus.quotient_sign  = r_qs;
    assign bus.remainder      = r_r;
    assign bus.remainder_sign = r_rs;
    assign bus.div_by_zero    = r_dbz;
endmodule

// File: tb/tb_sm_iter_divider.sv
// Bench for sm_iter_divider: WIDTH=3 and WIDTH=8 instances against
// an arithmetic reference model with directed and random operands.
module tb_sm_iter_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef SM_DIV_FAST_ZERO_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    sm_iter_divider_if #(.WIDTH(3)) b3 ();
    sm_iter_divider_if #(.WIDTH(8)) b8 ();

    sm_iter_divider #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    sm_iter_divider #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    int   checks = 0;
    int   failures = 0;
    logic sel = 1'b0;

    logic       s_done, s_busy, s_qs, s_rs, s_dz;
    logic [7:0] s_q, s_r;

    always_comb begin
        if (sel) begin
            s_done = b8.done;
            s_busy = b8.busy;
            s_q    = b8.quotient;
            s_qs   = b8.quotient_sign;
            s_r    = b8.remainder;
            s_rs   = b8.remainder_sign;
            s_dz   = b8.div_by_zero;
        end else begin
            s_done = b3.done;
            s_busy = b3.busy;
            s_q    = {5'd0, b3.quotient};
            s_qs   = b3.quotient_sign;
            s_r    = {5'd0, b3.remainder};
            s_rs   = b3.remainder_sign;
            s_dz   = b3.div_by_zero;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int w, input int a, input int asg,
                                  input int b, input int bsg,
                                  output int q, output int qs,
                                  output int r, output int rs,
                                  output int dz);
        if (b == 0) begin
            q  = (1 << w) - 1;
            qs = 1;
            r  = (1 << w) - 1;
            rs = 1;
            dz = 1;
        end else begin
            q  = a / b;
            r  = a % b;
            qs = (q != 0) ? (asg ^ bsg) : 0;
            rs = (r != 0) ? asg : 0;
            dz = 0;
        end
    endfunction

    task automatic drive(input int a, input int asg, input int b, input int bsg);
        if (sel) begin
            b8.dividend      = a[7:0];
            b8.dividend_sign = asg[0];
            b8.divisor       = b[7:0];
            b8.divisor_sign  = bsg[0];
        end else begin
            b3.dividend      = a[2:0];
            b3.dividend_sign = asg[0];
            b3.divisor       = b[2:0];
            b3.divisor_sign  = bsg[0];
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) b8.start = v;
        else     b3.start = v;
    endtask

    task automatic run_op(input logic w8, input int a, input int asg,
                          input int b, input int bsg, input bit mid);
        int q, qs, r, rs, dz, n, lat, w;
        string t;
        sel = w8;
        w = w8 ? 8 : 3;
        t = $sformatf("w%0d %s%0d/%s%0d", w, asg ? "-" : "+", a,
                      bsg ? "-" : "+", b);
        model(w, a, asg, b, bsg, q, qs, r, rs, dz);
        lat = (b == 0 || (FAST_ZERO && a == 0)) ? 0 : w;
        drive(a, asg, b, bsg);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        chk({t, " busy"}, int'(s_busy), 1);
        n = 0;
        while (!s_done && n < 40) begin
            if (mid && n == 2) begin
                drive(int'($urandom_range(0, 255)), 1, int'($urandom_range(0, 255)), 0);
                set_start(1'b1);
            end
            if (mid && n == 3) set_start(1'b0);
            @(posedge clk);
            #1;
            n++;
        end
        chk({t, " latency"}, n, lat);
        chk({t, " q"}, int'(s_q), q);
        chk({t, " qs"}, int'(s_qs), qs);
        chk({t, " r"}, int'(s_r), r);
        chk({t, " rs"}, int'(s_rs), rs);
        chk({t, " dbz"}, int'(s_dz), dz);
        @(posedge clk);
        #1;
        chk({t, " done_pulse"}, int'(s_done), 0);
        chk({t, " idle"}, int'(s_busy), 0);
    endtask

    task automatic reset_abort();
        int nd;
        sel = 1'b0;
        drive(7, 0, 2, 0);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rst busy", int'(s_busy), 0);
        chk("rst done", int'(s_done), 0);
        chk("rst q", int'(s_q), 0);
        chk("rst r", int'(s_r), 0);
        chk("rst qs", int'(s_qs), 0);
        chk("rst dbz", int'(s_dz), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nd = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (s_done) nd++;
        end
        chk("rst no_done", nd, 0);
    endtask

    initial begin
        b3.start = 1'b0;
        b8.start = 1'b0;
        sel = 1'b0;
        drive(0, 0, 0, 0);
        sel = 1'b1;
        drive(0, 0, 0, 0);
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", int'(b3.busy), 0);
        chk("reset done", int'(b3.done), 0);
        chk("reset q", int'(b3.quotient), 0);
        chk("reset r", int'(b3.remainder), 0);
        chk("reset signs", int'({b3.quotient_sign, b3.remainder_sign}), 0);
        chk("reset dbz", int'(b3.div_by_zero), 0);
        chk("reset w8 busy", int'(b8.busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(1'b0, 7, 0, 2, 0, 1'b0);
        run_op(1'b0, 7, 1, 2, 0, 1'b0);
        run_op(1'b0, 5, 0, 7, 1, 1'b0);
        run_op(1'b0, 3, 1, 0, 0, 1'b0);
        run_op(1'b0, 6, 0, 3, 0, 1'b0);
        reset_abort();
        run_op(1'b0, 6, 0, 4, 0, 1'b0);
        run_op(1'b0, 0, 1, 3, 0, 1'b0);
        run_op(1'b1, 200, 0, 7, 1, 1'b1);
        run_op(1'b1, 255, 1, 1, 1, 1'b0);
        run_op(1'b1, 0, 0, 9, 0, 1'b0);
        run_op(1'b1, 17, 0, 0, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic w8;
            int   mx, a, b;
            w8 = 1'($urandom_range(0, 1));
            mx = w8 ? 255 : 7;
            a  = int'($urandom_range(0, mx));
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, mx));
            run_op(w8, a, int'($urandom_range(0, 1)), b,
                   int'($urandom_range(0, 1)), 1'(i % 5 == 0 && w8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sm_iter_divider.md
Name: sm_iter_divider

Overview:
Parametrised sign-magnitude integer divider. It performs sequential restoring division, producing one quotient bit per cycle, and uses a start/busy/done handshake. It generalises the team's 3-bit combinational-registered divider to any magnitude width, with the same divide-by-zero encoding plus an explicit flag. It sits between the input pin decode and the output register bank of the top-level tile.

Parameters:
WIDTH, 3, magnitude width of the dividend, divisor, quotient and remainder (legal range 2..16).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  dividend magnitude
dividend_sign  input  1  dividend sign (1 = negative)
divisor  input  WIDTH  divisor magnitude
divisor_sign  input  1  divisor sign (1 = negative)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; results valid from this cycle onward
quotient  output  WIDTH  quotient magnitude
quotient_sign  output  1  quotient sign
remainder  output  WIDTH  remainder magnitude
remainder_sign  output  1  remainder sign
div_by_zero  output  1  last completed operation had divisor magnitude 0

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. busy, done, quotient, quotient_sign, remainder, remainder_sign and div_by_zero are all 0. Internal accumulator and counter are cleared.
- Reset asserted mid-operation aborts the division immediately. No done pulse is produced. Outputs return to 0.
- States: IDLE, RUN, DONE.
- IDLE: when start = 1 on edge E0, all operands are captured. Later input changes are ignored until the next accepted start.
  - divisor == 0: go to DONE.
  - otherwise: go to RUN with the counter loaded with WIDTH.
- RUN: each edge performs one restoring step, MSB first:
  - partial remainder is shifted left and the next dividend bit is brought in;
  - if partial remainder >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0;
  - the counter decrements.
  - On the edge where the counter goes 1 -> 0, load the outputs and go to DONE.
  - Partial remainder register is WIDTH+1 bits, so no overflow occurs.
- DONE: done = 1 for exactly one cycle, then IDLE on the next edge.
- Output registers change only on entry to DONE. They hold their values until the next result or reset.
- Latency: a normal division has done high in the cycle after edge E0+WIDTH. Divide-by-zero has done high in the cycle after E0. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy = 1 (RUN or DONE) is ignored. It is neither queued nor allowed to corrupt the operation in flight.
- Arithmetic: truncation toward zero.
  - quotient_sign = dividend_sign XOR divisor_sign, forced to 0 when the quotient magnitude is 0.
  - remainder_sign = dividend_sign, forced to 0 when the remainder magnitude is 0.
  - A magnitude of 0 with sign 1 (negative zero) is treated as zero.
- Divide-by-zero result: quotient = all ones, quotient_sign = 1, remainder = all ones, remainder_sign = 1, div_by_zero = 1.
- div_by_zero is cleared on the next non-zero-divisor result.

Optional Feature:
Macro: SM_DIV_FAST_ZERO_EN
- Defined: in IDLE, start with divisor != 0 and dividend == 0 goes directly to DONE. Result is all zeros with both signs 0, and done is high in the cycle after E0 (same one-cycle path as divide-by-zero).
- Not defined: a zero dividend runs all WIDTH iterations. It produces the identical all-zero result, with done high in the cycle after E0+WIDTH.
- Divide-by-zero takes priority over the zero-dividend check in both builds.

Test Plan:
- WIDTH=3: dividend 7(+), divisor 2(+), start -> done after 3 edges; q=3 q_sign=0, r=1 r_sign=0, div_by_zero=0.
- WIDTH=3: dividend 7(-), divisor 2(+) -> q=3 q_sign=1, r=1 r_sign=1. Then dividend 5(+), divisor 7(-) -> q=0 q_sign=0, r=5 r_sign=0.
- WIDTH=3: divisor 0 with any dividend -> done in the cycle after E0; q=7 q_sign=1, r=7 r_sign=1, div_by_zero=1. Next, 6/3 -> q=2, r=0, div_by_zero=0.
- WIDTH=8: dividend 200(+), divisor 7(-) -> done after 8 edges; q=28 q_sign=1, r=4 r_sign=0. Change operands and pulse start during RUN -> same result, no extra done.
- Assert rst_n low at iteration 2 of 7/2 -> outputs 0 immediately, no done pulse. After release, new start 6/4 -> q=1, r=2.
- Dividend 0(-), divisor 3(+) -> q=0, r=0, both signs 0. done after 1 edge with SM_DIV_FAST_ZERO_EN defined, after WIDTH edges without it.
